inv_nov_stepdown: RTL and testbench
===================================

INV_NOV_STEPDOWN -- requirements
Module: inv_nov_stepdown

Interface
REQ-001 Parameter WIDTH, default 2, number of independent inverter channels (range 1..16).
REQ-002 Parameter FILT, default 2, deglitch depth in clock cycles (range 1..15).
REQ-003 Parameter DEAD, default 3, break-before-make dead time in clock cycles (range 1..255).
REQ-004 Parameter INVERT, default 1, selects the legacy level output: 1 = o is the inverse of the filtered input, 0 = o equals the filtered input.
REQ-005 CELCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 CELRST  input  1  reset, synchronous and active-high.
REQ-007 CELV  input  1  supply; CELG  input  1  ground; SUB  input  1  substrate; these are connectivity only and have no logic function.
REQ-008 CELEN  input  1  global driver enable.
REQ-009 i  input  WIDTH  asynchronous per-channel command.
REQ-010 o  output  WIDTH  filtered level output, polarity per INVERT.
REQ-011 oh  output  WIDTH  high-side drive, per channel.
REQ-012 ol  output  WIDTH  low-side drive, per channel.
REQ-013 busy  output  WIDTH  per channel; 1 while that channel is in DT_UP or DT_DN.

Function
REQ-014 Each channel passes i[k] through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 Each channel holds a filtered level f[k] and a filter counter; the counter increments each cycle that s2 differs from f, clears on any cycle they match, and f takes the value of s2 on the edge where the count reaches FILT.
REQ-016 Latency from a clean i[k] change, set up before edge 1, to the f[k] change is 2+FILT edges; pulses shorter than FILT cycles after synchronization do not change f[k].
REQ-017 o[k] = f[k] XOR INVERT, decoded directly from registered state with no added cycle.
REQ-018 Each channel has a state machine with states OFF (oh=0, ol=0), LOW (ol=1), DT_UP (both 0), HIGH (oh=1), DT_DN (both 0); oh and ol are decoded from state only.
REQ-019 LOW with f=1 -> DT_UP; counter loaded so the channel stays in DT_UP for exactly DEAD cycles, then enters HIGH.
REQ-020 HIGH with f=0 -> DT_DN for exactly DEAD cycles, then LOW.
REQ-021 In DT_UP with f=0 -> LOW on the next edge, with no dead time because oh was never asserted; in DT_DN with f=1 -> HIGH on the next edge, with the same rule.
REQ-022 CELEN=0 forces every channel from any state to OFF on the next edge; while CELEN=0, the synchronizer, filter and o keep running.
REQ-023 OFF with CELEN=1: f=0 -> LOW on the next edge; f=1 -> DT_UP, then HIGH after DEAD cycles.
REQ-024 oh[k] and ol[k] are never both 1 in any cycle, under any stimulus.
REQ-025 Channels are fully independent; simultaneous events on different channels are handled per channel with no interaction.

Reset
REQ-026 CELRST=1 on an edge sets s1=s2=0, f=0, filter and dead-time counters to 0, and state OFF; it overrides CELEN and i.
REQ-027 Output values while CELRST is asserted and after it: oh=0, ol=0, busy=0, o={WIDTH{INVERT}}; reset asserted mid-dead-time aborts the dead time immediately.
REQ-028 First edge after reset release with CELEN=1 and i=0: LOW.

Verification (WIDTH=2, FILT=2, DEAD=3, INVERT=1, CELEN=1 unless stated)
REQ-029 Assert CELRST for 3 cycles -> oh=2'b00, ol=2'b00, o=2'b11, busy=2'b00; one edge after release, ol=2'b11.
REQ-030 From LOW, i[0] rises before edge 1 -> o[0]=0 from edge 4; ol[0]=0 and busy[0]=1 from edge 5; oh[0]=1 and busy[0]=0 from edge 8; channel 1 is unchanged throughout.
REQ-031 i[1] high for 1 cycle only -> o[1], oh[1] and ol[1] never change.
REQ-032 i[0] rises, then falls as soon as the channel enters DT_UP -> ol[0] returns to 1 without oh[0] ever asserting; oh&ol==0 in every cycle.
REQ-033 Channel 0 in HIGH, CELEN dropped for 5 cycles -> oh[0]=0 one edge later; after CELEN is restored, oh[0]=1 DEAD+1=4 edges after CELEN rises.
REQ-034 CELRST asserted while channel 0 is in DT_DN -> all outputs take their reset values on the next edge; a constrained-random run of 10k cycles shows no cycle with oh[k]&ol[k]=1.

Source files
------------

// File: rtl/inv_nov_stepdown.sv
// inv_nov_stepdown: per-channel deglitched inverter with break-before-make
// high/low side drivers. Each channel synchronizes its command and filters
// it. A small state machine then inserts DEAD cycles of dead time between
// the low-side drive turning off and the high-side drive turning on, and
// the same between the high-side drive turning off and the low-side drive
// turning on.

module inv_nov_stepdown #(
  parameter int WIDTH  = 2,
  parameter int FILT   = 2,
  parameter int DEAD   = 3,
  parameter int INVERT = 1
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             CELEN,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] oh,
  output logic [WIDTH-1:0] ol,
  output logic [WIDTH-1:0] busy
);

  typedef enum logic [2:0] {
    st_off,
    st_low,
    st_dt_up,
    st_high,
    st_dt_dn
  } state_t;

  // The filter fires when the mismatch count has already reached FILT-1
  // and the current cycle still mismatches.
  localparam logic [3:0] filt_last = 4'(FILT - 1);
  // The dead-time counter counts down to zero, so loading DEAD-1 gives DEAD cycles.
  localparam logic [7:0] dead_load = 8'(DEAD - 1);
  localparam logic       inv_bit   = (INVERT != 0);

  // Supply, ground and substrate pins exist only for connectivity.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  genvar k;
  for (k = 0; k < WIDTH; k++) begin : g_ch
    logic       s1;
    logic       s2;
    logic       f;
    logic [3:0] fcnt;
    logic [7:0] dcnt;
    state_t     state;

    // Two-flop synchronizer for the asynchronous command input.
    always_ff @(posedge CELCLK) begin
      if (CELRST) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= i[k];
        s2 <= s1;
      end
    end

    // Deglitch: f only follows s2 after FILT consecutive mismatching cycles.
    always_ff @(posedge CELCLK) begin
      if (CELRST) begin
        f    <= 1'b0;
        fcnt <= '0;
      end else if (s2 != f) begin
        if (fcnt == filt_last) begin
          f    <= s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end else begin
        fcnt <= '0;
      end
    end

    // Driver sequencing. Dead time is skipped when a pending turn-on is
    // cancelled, because the opposite switch was never driven.
    always_ff @(posedge CELCLK) begin
      if (CELRST || !CELEN) begin
        state <= st_off;
        dcnt  <= '0;
      end else begin
        case (state)
          st_off: begin
            if (f) begin
              state <= st_dt_up;
              dcnt  <= dead_load;
            end else begin
              state <= st_low;
            end
          end
          st_low: begin
            if (f) begin
              state <= st_dt_up;
              dcnt  <= dead_load;
            end
          end
          st_dt_up: begin
            if (!f) begin
              state <= st_low;
              dcnt  <= '0;
            end else if (dcnt == 8'd0) begin
              state <= st_high;
            end else begin
              dcnt <= dcnt - 8'd1;
            end
          end
          st_high: begin
            if (!f) begin
              state <= st_dt_dn;
              dcnt  <= dead_load;
            end
          end
          st_dt_dn: begin
            if (f) begin
              state <= st_high;
              dcnt  <= '0;
            end else if (dcnt == 8'd0) begin
              state <= st_low;
            end else begin
              dcnt <= dcnt - 8'd1;
            end
          end
          default: begin
            state <= st_off;
            dcnt  <= '0;
          end
        endcase
      end
    end

    assign o[k]    = f ^ inv_bit;
    assign oh[k]   = (state == st_high);
    assign ol[k]   = (state == st_low);
    assign busy[k] = (state == st_dt_up) || (state == st_dt_dn);
  end

endmodule

// File: tb/tb_inv_nov_stepdown.sv
// tb_inv_nov_stepdown: self-checking bench for inv_nov_stepdown using a
// constant vector table, hand-written corner sequences, and a randomized
// run compared against a behavioural model.

module tb_inv_nov_stepdown;

  localparam int WIDTH  = 2;
  localparam int FILT   = 2;
  localparam int DEAD   = 3;
  localparam int INVERT = 1;

  localparam int M_OFF  = 0;
  localparam int M_LOW  = 1;
  localparam int M_UP   = 2;
  localparam int M_HIGH = 3;
  localparam int M_DN   = 4;

  logic             CELCLK;
  logic             CELRST;
  logic             CELV;
  logic             CELG;
  logic             SUB;
  logic             CELEN;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] oh;
  logic [WIDTH-1:0] ol;
  logic [WIDTH-1:0] busy;

  int testsRun  = 0;
  int testsFail = 0;

  // Behavioural model state: synchronizer stages, a history of synchronized
  // samples, the filtered level, the driver mode and time spent in dead time.
  logic        mS1   [WIDTH];
  logic        mS2   [WIDTH];
  logic [15:0] mHist [WIDTH];
  logic        mF    [WIDTH];
  int          mMode [WIDTH];
  int          mEl   [WIDTH];

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] iv;
    logic [1:0] eo;
    logic [1:0] eoh;
    logic [1:0] eol;
    logic [1:0] ebusy;
  } vec_t;

  vec_t tbl [14];

  inv_nov_stepdown #(
    .WIDTH (WIDTH),
    .FILT  (FILT),
    .DEAD  (DEAD),
    .INVERT(INVERT)
  ) dut (
    .CELCLK(CELCLK),
    .CELRST(CELRST),
    .CELV  (CELV),
    .CELG  (CELG),
    .SUB   (SUB),
    .CELEN (CELEN),
    .i     (i),
    .o     (o),
    .oh    (oh),
    .ol    (ol),
    .busy  (busy)
  );

  // Free-running clock, period 10.
  initial begin
    CELCLK = 1'b0;
    forever #5 CELCLK = ~CELCLK;
  end

  // Advance the behavioural model by one rising edge.
  task automatic modelEdge(input logic rst, input logic en, input logic [WIDTH-1:0] iv);
    logic [15:0] mask;
    logic        oldF;
    mask = 16'((1 << FILT) - 1);
    for (int k = 0; k < WIDTH; k++) begin
      if (rst) begin
        mS1[k]   = 1'b0;
        mS2[k]   = 1'b0;
        mHist[k] = '0;
        mF[k]    = 1'b0;
        mMode[k] = M_OFF;
        mEl[k]   = 0;
      end else begin
        oldF     = mF[k];
        mHist[k] = {mHist[k][14:0], mS2[k]};
        if ((mHist[k] & mask) == (oldF ? 16'd0 : mask)) mF[k] = ~oldF;
        mS2[k] = mS1[k];
        mS1[k] = iv[k];
        if (!en) begin
          mMode[k] = M_OFF;
          mEl[k]   = 0;
        end else begin
          case (mMode[k])
            M_OFF:  begin mMode[k] = oldF ? M_UP : M_LOW; mEl[k] = 0; end
            M_LOW:  if (oldF) begin mMode[k] = M_UP; mEl[k] = 0; end
            M_UP: begin
              if (!oldF) mMode[k] = M_LOW;
              else if (mEl[k] + 1 == DEAD) mMode[k] = M_HIGH;
              else mEl[k] = mEl[k] + 1;
            end
            M_HIGH: if (!oldF) begin mMode[k] = M_DN; mEl[k] = 0; end
            M_DN: begin
              if (oldF) mMode[k] = M_HIGH;
              else if (mEl[k] + 1 == DEAD) mMode[k] = M_LOW;
              else mEl[k] = mEl[k] + 1;
            end
            default: mMode[k] = M_OFF;
          endcase
        end
      end
    end
  endtask

  // Drive inputs, take one rising edge, update the model, settle 1 time unit.
  task automatic applyStimulus(input logic rst, input logic en, input logic [WIDTH-1:0] iv);
    CELRST = rst;
    CELEN  = en;
    i      = iv;
    @(posedge CELCLK);
    modelEdge(rst, en, iv);
    #1;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] eo,
                             input logic [WIDTH-1:0] eoh, input logic [WIDTH-1:0] eol,
                             input logic [WIDTH-1:0] ebusy);
    testsRun += 5;
    if (o !== eo) begin
      testsFail++;
      $display("[TB] FAIL %s o: got %b expected %b at %0t", name, o, eo, $time);
    end
    if (oh !== eoh) begin
      testsFail++;
      $display("[TB] FAIL %s oh: got %b expected %b at %0t", name, oh, eoh, $time);
    end
    if (ol !== eol) begin
      testsFail++;
      $display("[TB] FAIL %s ol: got %b expected %b at %0t", name, ol, eol, $time);
    end
    if (busy !== ebusy) begin
      testsFail++;
      $display("[TB] FAIL %s busy: got %b expected %b at %0t", name, busy, ebusy, $time);
    end
    if ((oh & ol) !== '0) begin
      testsFail++;
      $display("[TB] FAIL %s overlap: got oh&ol=%b expected 00 at %0t", name, oh & ol, $time);
    end
  endtask

  task automatic checkModel(input string name);
    logic [WIDTH-1:0] eo, eoh, eol, ebusy;
    for (int k = 0; k < WIDTH; k++) begin
      eo[k]    = mF[k] ^ (INVERT != 0);
      eoh[k]   = (mMode[k] == M_HIGH);
      eol[k]   = (mMode[k] == M_LOW);
      ebusy[k] = (mMode[k] == M_UP) || (mMode[k] == M_DN);
    end
    checkOutput(name, eo, eoh, eol, ebusy);
  endtask

  initial begin
    logic             ohSeen;
    logic [WIDTH-1:0] rv;
    logic             ren;
    logic             rrst;

    CELV   = 1'b1;
    CELG   = 1'b0;
    SUB    = 1'b0;
    CELRST = 1'b1;
    CELEN  = 1'b1;
    i      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      mS1[k] = 0; mS2[k] = 0; mHist[k] = '0; mF[k] = 0; mMode[k] = M_OFF; mEl[k] = 0;
    end

    // Reset for 3 cycles, release into LOW, then a rising command on channel 0.
    //            rst   en    iv     o      oh     ol     busy
    tbl[0]  = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[6]  = '{1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    tbl[10] = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    tbl[11] = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    tbl[12] = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

    for (int r = 0; r < 14; r++) begin
      applyStimulus(tbl[r].rst, tbl[r].en, tbl[r].iv);
      checkOutput($sformatf("vec%0d", r), tbl[r].eo, tbl[r].eoh, tbl[r].eol, tbl[r].ebusy);
    end

    // One-cycle glitch on channel 1 must not disturb anything.
    applyStimulus(1'b0, 1'b1, 2'b11);
    checkOutput("glitch", 2'b10, 2'b01, 2'b10, 2'b00);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1, 2'b01);
      checkOutput("glitch", 2'b10, 2'b01, 2'b10, 2'b00);
    end

    // Bring channel 0 back to LOW through DT_DN.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, 2'b00);
      checkModel("fall");
    end
    checkOutput("fall_end", 2'b11, 2'b00, 2'b11, 2'b00);

    // Pulse just long enough to pass the filter: the fall lands in DT_UP.
    ohSeen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b1, (c <= 2) ? 2'b01 : 2'b00);
      checkModel("abort_up");
      ohSeen = ohSeen | oh[0];
      if (c == 5) checkBit("abort_up_busy", busy[0], 1'b1);
      if (c == 7) checkBit("abort_up_ol", ol[0], 1'b1);
    end
    checkBit("abort_up_no_oh", ohSeen, 1'b0);

    // Channel 0 to HIGH, then drop the enable for 5 cycles and restore it.
    for (int c = 0; c < 12; c++) applyStimulus(1'b0, 1'b1, 2'b01);
    checkOutput("pre_en", 2'b10, 2'b01, 2'b10, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b0, 2'b01);
      checkOutput("en_low", 2'b10, 2'b00, 2'b00, 2'b00);
    end
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 1'b1, 2'b01);
      checkModel("en_back");
      if (c == 3) checkOutput("en_back3", 2'b10, 2'b00, 2'b10, 2'b01);
      if (c == 4) checkOutput("en_back4", 2'b10, 2'b01, 2'b10, 2'b00);
    end

    // Reset in the middle of DT_DN aborts it at once.
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("in_dt_dn", 2'b11, 2'b00, 2'b10, 2'b01);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkOutput("rst_dt_dn", 2'b11, 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("rst_release", 2'b11, 2'b00, 2'b11, 2'b00);

    // Constrained-random run against the model.
    rv = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < WIDTH; k++)
        if ($urandom_range(0, 3) == 0) rv[k] = ~rv[k];
      ren  = ($urandom_range(0, 29) != 0);
      rrst = ($urandom_range(0, 299) == 0);
      applyStimulus(rrst, ren, rv);
      checkModel("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
